dcache_line_adapter: RTL and testbench

- Sits directly downstream of the data cache. Converts the cache's single-cycle 256-bit line request (pmem_* side) into a 4-beat, 64-bit burst transaction on the physical memory bus, and the reverse.
- Latches address and write line at request. Assembles read beats into a line. Returns one resp pulse to the cache per completed line.

---
 rtl/dcache_pkg.sv | 23 ++
 rtl/dcache_line_adapter_line_beat_buffer.sv | 37 +++
 rtl/dcache_line_adapter.sv | 181 ++++++++++++++++++
 tb/tb_dcache_line_adapter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache line adapter.
// The adapter moves one cache line as a fixed four-beat burst on the memory bus.
package dcache_pkg;

  localparam int unsigned DC_LINE_WIDTH  = 256;
  localparam int unsigned DC_BURST_WIDTH = 64;
  localparam int unsigned DC_ADDR_WIDTH  = 32;
  localparam int unsigned DC_OFFSET_BITS = 5;
  localparam int unsigned DC_BEATS       = DC_LINE_WIDTH / DC_BURST_WIDTH;
  localparam int unsigned DC_CNT_WIDTH   = $clog2(DC_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef logic [DC_CNT_WIDTH-1:0] beat_cnt_t;

  localparam beat_cnt_t DC_LAST_BEAT = beat_cnt_t'(DC_BEATS - 1);

endpackage

// File: rtl/dcache_line_adapter_line_beat_buffer.sv
// Line-wide holding register shared by both burst directions.
// Loads a whole line for write-back or one beat at a time for read assembly.
module line_beat_buffer
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_WIDTH  = DC_LINE_WIDTH,
  parameter int unsigned BURST_WIDTH = DC_BURST_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_load_line,
  input  logic [LINE_WIDTH-1:0]  i_line,
  input  logic                   i_load_beat,
  input  beat_cnt_t              i_beat_idx,
  input  logic [BURST_WIDTH-1:0] i_beat,
  input  beat_cnt_t              i_sel_idx,
  output logic [LINE_WIDTH-1:0]  o_line,
  output logic [BURST_WIDTH-1:0] o_sel_beat_c
);

  logic [LINE_WIDTH-1:0] r_line;

  // Whole-line load wins; the FSM never asserts both loads together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
    end else if (i_load_line) begin
      r_line <= i_line;
    end else if (i_load_beat) begin
      r_line[BURST_WIDTH*i_beat_idx +: BURST_WIDTH] <= i_beat;
    end
  end

  assign o_line       = r_line;
  assign o_sel_beat_c = r_line[BURST_WIDTH*i_sel_idx +: BURST_WIDTH];

endmodule

// File: rtl/dcache_line_adapter.sv
// Converts single-cycle 256-bit cache line requests into 4-beat 64-bit
// memory bursts and returns one completion pulse per line.
module dcache_line_adapter
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_WIDTH  = DC_LINE_WIDTH,
  parameter int unsigned BURST_WIDTH = DC_BURST_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DC_ADDR_WIDTH,
  parameter int unsigned OFFSET_BITS = DC_OFFSET_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  line_address_i,
  input  logic                   line_read_i,
  input  logic                   line_write_i,
  input  logic [LINE_WIDTH-1:0]  line_wdata_i,
  output logic [LINE_WIDTH-1:0]  line_rdata_o,
  output logic                   line_resp_o,
  output logic [ADDR_WIDTH-1:0]  burst_address_o,
  output logic                   burst_read_o,
  output logic                   burst_write_o,
  output logic [BURST_WIDTH-1:0] burst_wdata_o,
  input  logic [BURST_WIDTH-1:0] burst_rdata_i,
  input  logic                   burst_resp_i
);

  generate
    if (LINE_WIDTH != 4 * BURST_WIDTH) begin : g_width_check
      $error("dcache_line_adapter: LINE_WIDTH must equal 4*BURST_WIDTH");
    end
  endgenerate

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

  state_e                 r_state, w_state_nxt;
  beat_cnt_t              r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [ADDR_WIDTH-1:0]  r_addr, w_addr_nxt, w_aligned_addr;
  logic                   r_burst_read, w_burst_read_nxt;
  logic                   r_burst_write, w_burst_write_nxt;
  logic                   r_line_resp, w_line_resp_nxt;
  logic [BURST_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic [LINE_WIDTH-1:0]  r_line_rdata, w_line_rdata_nxt;
  logic                   w_last_beat;
  logic                   w_buf_load_line, w_buf_load_beat;
  logic [LINE_WIDTH-1:0]  w_buf_line, w_rd_line_full;
  logic [BURST_WIDTH-1:0] w_sel_beat;

  assign w_aligned_addr = line_address_i & ADDR_MASK;
  assign w_cnt_inc      = r_cnt + beat_cnt_t'(1);
  assign w_last_beat    = burst_resp_i && (r_cnt == DC_LAST_BEAT);

  line_beat_buffer #(
    .LINE_WIDTH  (LINE_WIDTH),
    .BURST_WIDTH (BURST_WIDTH)
  ) u_buf (
    .clk          (clk),
    .rst_n        (rst),
    .i_load_line  (w_buf_load_line),
    .i_line       (line_wdata_i),
    .i_load_beat  (w_buf_load_beat),
    .i_beat_idx   (r_cnt),
    .i_beat       (burst_rdata_i),
    .i_sel_idx    (w_cnt_inc),
    .o_line       (w_buf_line),
    .o_sel_beat_c (w_sel_beat)
  );

  // Completed read line: buffered beats with the final beat merged in.
  always_comb begin
    w_rd_line_full = w_buf_line;
    w_rd_line_full[BURST_WIDTH*r_cnt +: BURST_WIDTH] = burst_rdata_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (line_write_i) begin
          w_state_nxt = ST_WRITE;
        end else if (line_read_i) begin
          w_state_nxt = ST_READ;
        end
      end
      ST_READ:  if (w_last_beat) w_state_nxt = ST_DONE;
      ST_WRITE: if (w_last_beat) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath controls.
  always_comb begin
    w_cnt_nxt         = r_cnt;
    w_addr_nxt        = r_addr;
    w_burst_read_nxt  = 1'b0;
    w_burst_write_nxt = 1'b0;
    w_line_resp_nxt   = 1'b0;
    w_wdata_nxt       = '0;
    w_line_rdata_nxt  = r_line_rdata;
    w_buf_load_line   = 1'b0;
    w_buf_load_beat   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (line_write_i) begin
          w_addr_nxt        = w_aligned_addr;
          w_cnt_nxt         = '0;
          w_buf_load_line   = 1'b1;
          w_burst_write_nxt = 1'b1;
          w_wdata_nxt       = line_wdata_i[BURST_WIDTH-1:0];
        end else if (line_read_i) begin
          w_addr_nxt       = w_aligned_addr;
          w_cnt_nxt        = '0;
          w_burst_read_nxt = 1'b1;
        end
      end
      ST_READ: begin
        w_burst_read_nxt = !w_last_beat;
        if (burst_resp_i) begin
          w_buf_load_beat = 1'b1;
          w_cnt_nxt       = w_cnt_inc;
        end
        if (w_last_beat) begin
          w_line_resp_nxt  = 1'b1;
          w_line_rdata_nxt = w_rd_line_full;
        end
      end
      ST_WRITE: begin
        w_burst_write_nxt = !w_last_beat;
        w_wdata_nxt       = r_wdata;
        if (burst_resp_i) begin
          w_cnt_nxt   = w_cnt_inc;
          w_wdata_nxt = w_last_beat ? '0 : w_sel_beat;
        end
        if (w_last_beat) begin
          w_line_resp_nxt = 1'b1;
        end
      end
      ST_DONE: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt         <= '0;
      r_addr        <= '0;
      r_burst_read  <= 1'b0;
      r_burst_write <= 1'b0;
      r_line_resp   <= 1'b0;
      r_wdata       <= '0;
      r_line_rdata  <= '0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_addr        <= w_addr_nxt;
      r_burst_read  <= w_burst_read_nxt;
      r_burst_write <= w_burst_write_nxt;
      r_line_resp   <= w_line_resp_nxt;
      r_wdata       <= w_wdata_nxt;
      r_line_rdata  <= w_line_rdata_nxt;
    end
  end

  assign line_rdata_o    = r_line_rdata;
  assign line_resp_o     = r_line_resp;
  assign burst_address_o = r_addr;
  assign burst_read_o    = r_burst_read;
  assign burst_write_o   = r_burst_write;
  assign burst_wdata_o   = r_wdata;

endmodule

// File: tb/tb_dcache_line_adapter.sv
// Self-checking bench for dcache_line_adapter: directed and random line
// transactions against a memory/cache model driven from one initial block.
module tb_dcache_line_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  line_address_i;
  logic         line_read_i;
  logic         line_write_i;
  logic [255:0] line_wdata_i;
  logic [255:0] line_rdata_o;
  logic         line_resp_o;
  logic [31:0]  burst_address_o;
  logic         burst_read_o;
  logic         burst_write_o;
  logic [63:0]  burst_wdata_o;
  logic [63:0]  burst_rdata_i;
  logic         burst_resp_i;

  int total = 0;
  int bad   = 0;
  int cyc_g = 0;
  logic [255:0] last_rd = '0;

  always #5 clk = ~clk;

  dcache_line_adapter dut (
    .clk             (clk),
    .rst             (rst),
    .line_address_i  (line_address_i),
    .line_read_i     (line_read_i),
    .line_write_i    (line_write_i),
    .line_wdata_i    (line_wdata_i),
    .line_rdata_o    (line_rdata_o),
    .line_resp_o     (line_resp_o),
    .burst_address_o (burst_address_o),
    .burst_read_o    (burst_read_o),
    .burst_write_o   (burst_write_o),
    .burst_wdata_o   (burst_wdata_o),
    .burst_rdata_i   (burst_rdata_i),
    .burst_resp_i    (burst_resp_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_g++;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, line_rdata_o, '0);
    chk({tag, "_resp"}, 256'(line_resp_o), '0);
    chk({tag, "_addr"}, 256'(burst_address_o), '0);
    chk({tag, "_rd"}, 256'(burst_read_o), '0);
    chk({tag, "_wr"}, 256'(burst_write_o), '0);
    chk({tag, "_wdata"}, 256'(burst_wdata_o), '0);
  endtask

  // One line transaction: acts as the cache (holds request until resp) and
  // as memory (strobes each beat after waits[k] idle cycles).
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [255:0] wline, input logic [255:0] rline,
                     input logic [3:0][7:0] waits, output int resp_at);
    bit          is_wr    = wr;
    logic [31:0] exp_addr = addr & ~32'h1f;
    int          exp_lat  = 5;
    int          k        = 0;
    int          wleft;
    bit          done     = 1'b0;
    for (int i = 0; i < 4; i++) exp_lat += int'(waits[i]);
    resp_at = -1;
    chk("idle_rdata_hold", line_rdata_o, last_rd);
    line_address_i = addr;
    line_read_i    = rd;
    line_write_i   = wr;
    line_wdata_i   = wline;
    burst_resp_i   = 1'b0;
    wleft = int'(waits[0]);
    for (int c = 1; c <= 200 && !done; c++) begin
      tick();
      burst_resp_i  = 1'b0;
      burst_rdata_i = {$urandom, $urandom};
      if (line_resp_o) begin
        resp_at = cyc_g;
        chk("resp_latency", 256'(c), 256'(exp_lat));
        chk("beats_before_resp", 256'(k), 256'(4));
        chk("req_dropped", 256'({burst_read_o, burst_write_o}), '0);
        if (!is_wr) begin
          chk("read_line", line_rdata_o, rline);
          last_rd = rline;
        end
        line_read_i  = 1'b0;
        line_write_i = 1'b0;
        tick();
        chk("resp_single", 256'(line_resp_o), '0);
        done = 1'b1;
      end else if (k < 4) begin
        chk("burst_addr", 256'(burst_address_o), 256'(exp_addr));
        chk("burst_read", 256'(burst_read_o), 256'(!is_wr));
        chk("burst_write", 256'(burst_write_o), 256'(is_wr));
        if (is_wr) chk("burst_wdata", 256'(burst_wdata_o), 256'(wline[64*k +: 64]));
        if (wleft > 0) begin
          wleft--;
        end else begin
          burst_resp_i  = 1'b1;
          burst_rdata_i = rline[64*k +: 64];
          k++;
          if (k < 4) wleft = int'(waits[k]);
        end
      end else begin
        chk("resp_after_last_beat", 256'(line_resp_o), 256'(1));
      end
    end
    chk("txn_completed", 256'(done), 256'(1));
  endtask

  initial begin
    logic [3:0][7:0] w0;
    logic [3:0][7:0] w;
    logic [255:0]    l1;
    logic [255:0]    l2;
    int              r1;
    int              r2;
    bit              rd;
    bit              wr;

    rst            = 1'b0;
    line_address_i = '0;
    line_read_i    = 1'b0;
    line_write_i   = 1'b0;
    line_wdata_i   = '0;
    burst_rdata_i  = '0;
    burst_resp_i   = 1'b0;
    w0             = '0;
    #2;
    chk_all_zero("reset");
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Directed read of 0x1234, immediate strobes.
    l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    txn(1'b1, 1'b0, 32'h0000_1234, '0, l1, w0, r1);

    // Directed write, quarters made distinct.
    l2 = {8{32'hDEAD_BEEF}};
    for (int q = 0; q < 4; q++) l2[64*q +: 64] = l2[64*q +: 64] ^ 64'(q + 1);
    txn(1'b0, 1'b1, 32'h0000_8040, l2, '0, w0, r1);

    // Read with three idle cycles between the first and second beats.
    w = '0;
    w[1] = 8'd3;
    txn(1'b1, 1'b0, 32'h0000_1234, '0, l1, w, r1);

    // Reset in the middle of a write, after the first beat is accepted.
    line_address_i = 32'h0000_2000;
    line_wdata_i   = rnd_line();
    line_write_i   = 1'b1;
    tick();
    burst_resp_i = 1'b1;
    tick();
    burst_resp_i = 1'b0;
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    last_rd      = '0;
    line_write_i = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_resp", 256'(line_resp_o), '0);
      chk("post_reset_busy", 256'({burst_read_o, burst_write_o}), '0);
    end
    txn(1'b1, 1'b0, $urandom, '0, rnd_line(), w0, r1);

    // Both requests high: write wins, read never asserted.
    txn(1'b1, 1'b1, $urandom, rnd_line(), '0, w0, r1);

    // Stray strobes while idle do nothing.
    burst_resp_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      burst_rdata_i = {$urandom, $urandom};
      tick();
      chk("idle_strobe_resp", 256'(line_resp_o), '0);
      chk("idle_strobe_busy", 256'({burst_read_o, burst_write_o}), '0);
      chk("idle_strobe_rdata", line_rdata_o, last_rd);
    end
    burst_resp_i = 1'b0;

    // Back-to-back read then write.
    txn(1'b1, 1'b0, $urandom, '0, rnd_line(), w0, r1);
    txn(1'b0, 1'b1, $urandom, rnd_line(), '0, w0, r2);
    chk("b2b_gap", 256'((r2 - r1) >= 2), 256'(1));

    // Random mix of directions, data and wait patterns.
    for (int t = 0; t < 10; t++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      for (int i = 0; i < 4; i++) w[i] = 8'($urandom_range(0, 3));
      txn(rd, wr, $urandom, rnd_line(), rnd_line(), w, r1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
